// File: rtl/t08_imem_fetch_ctrl.sv
// Instruction-memory fetch controller: one read per instruction, holds the word for the decoder.
// Optional bus-wait timeout with sticky fetch_fault is compiled in with T08_IFETCH_TIMEOUT_EN.
module t08_imem_fetch_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [31:0] pc,
  input  logic        mem_busy,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_read,
  output logic [31:0] mem_addr,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        counter_on,
  output logic        misaligned,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        misaligned_q, misaligned_d;
  logic [31:0] addr_q, addr_d;
  logic        pc_aligned;

  assign pc_aligned = (pc[1:0] == 2'b00);

`ifdef T08_IFETCH_TIMEOUT_EN
  logic [31:0] wait_cnt_q, wait_cnt_d;
  logic        fault_q, fault_d;
  logic        timeout_hit;

  // Counts every cycle spent waiting on the bus for the current instruction.
  assign timeout_hit = ((state_q == REQ) || (state_q == WAIT)) &&
                       (wait_cnt_q == (TIMEOUT_CYCLES - 32'd1));
`endif

  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    misaligned_d = misaligned_q;
    addr_d       = addr_q;
`ifdef T08_IFETCH_TIMEOUT_EN
    fault_d      = fault_q;
    wait_cnt_d   = wait_cnt_q;
`endif

    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (!pc_aligned) begin
          instr_d      = NOP_INSTR;
          misaligned_d = 1'b1;
          state_d      = HOLD;
        end else if (!mem_busy) begin
          addr_d  = pc;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_ack) begin
          instr_d      = mem_rdata;
          misaligned_d = 1'b0;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef T08_IFETCH_TIMEOUT_EN
    // An ack or a misaligned PC in the final cycle still wins over the timeout.
    if (timeout_hit && (state_d != HOLD)) begin
      fault_d      = 1'b1;
      instr_d      = NOP_INSTR;
      misaligned_d = 1'b0;
      state_d      = HOLD;
    end

    if ((state_d == REQ) && (state_q != REQ)) begin
      wait_cnt_d = 32'd0;
    end else if ((state_q == REQ) || (state_q == WAIT)) begin
      wait_cnt_d = wait_cnt_q + 32'd1;
    end
`endif

    valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      instr_q      <= NOP_INSTR;
      valid_q      <= 1'b0;
      misaligned_q <= 1'b0;
      addr_q       <= 32'd0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      valid_q      <= valid_d;
      misaligned_q <= misaligned_d;
      addr_q       <= addr_d;
    end
  end

`ifdef T08_IFETCH_TIMEOUT_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wait_cnt_q <= 32'd0;
      fault_q    <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      fault_q    <= fault_d;
    end
  end

  assign fetch_fault = fault_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign fetch_fault    = 1'b0;
`endif

  always_comb begin
    mem_read   = 1'b0;
    mem_addr   = 32'd0;
    counter_on = 1'b0;
    unique case (state_q)
      REQ: begin
        mem_read = pc_aligned;
        mem_addr = pc;
      end
      WAIT: mem_addr = addr_q;
      // PC stage advances on the same edge the decoder takes the word.
      HOLD: counter_on = instr_ready;
      default: ;
    endcase
  end

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign misaligned  = misaligned_q;

endmodule

// File: tb/tb_t08_imem_fetch_ctrl.sv
// Directed bench for t08_imem_fetch_ctrl; covers the timeout path when T08_IFETCH_TIMEOUT_EN is defined.
module tb_t08_imem_fetch_ctrl;

  logic        clk;
  logic        nrst;
  logic [31:0] pc;
  logic        memBusy;
  logic        memAck;
  logic [31:0] memRdata;
  logic        memRead;
  logic [31:0] memAddr;
  logic [31:0] instr;
  logic        instrValid;
  logic        instrReady;
  logic        counterOn;
  logic        misaligned;
  logic        fetchFault;

  int errorCount = 0;
  int checkCount = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  t08_imem_fetch_ctrl #(
    .TIMEOUT_CYCLES(8),
    .NOP_INSTR     (NOP)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .pc         (pc),
    .mem_busy   (memBusy),
    .mem_ack    (memAck),
    .mem_rdata  (memRdata),
    .mem_read   (memRead),
    .mem_addr   (memAddr),
    .instr      (instr),
    .instr_valid(instrValid),
    .instr_ready(instrReady),
    .counter_on (counterOn),
    .misaligned (misaligned),
    .fetch_fault(fetchFault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Drives this cycle's inputs shortly after the clock edge and lets combinational outputs settle.
  task automatic applyStimulus(input logic [31:0] pcIn, input logic busy, input logic ack,
                               input logic [31:0] rdata, input logic ready);
    pc         = pcIn;
    memBusy    = busy;
    memAck     = ack;
    memRdata   = rdata;
    instrReady = ready;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".mem_read"}, {31'd0, memRead}, 32'd0);
    checkOutput({tag, ".mem_addr"}, memAddr, 32'd0);
    checkOutput({tag, ".instr"}, instr, NOP);
    checkOutput({tag, ".instr_valid"}, {31'd0, instrValid}, 32'd0);
    checkOutput({tag, ".counter_on"}, {31'd0, counterOn}, 32'd0);
    checkOutput({tag, ".misaligned"}, {31'd0, misaligned}, 32'd0);
    checkOutput({tag, ".fetch_fault"}, {31'd0, fetchFault}, 32'd0);
  endtask

  initial begin
    nrst = 1'b0;
    applyStimulus(32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    checkResetValues("reset");
    nextCycle();

    // Basic fetch at pc 0: IDLE, REQ, WAIT(ack), HOLD(ready).
    nrst = 1'b1;
    applyStimulus(32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("idle.mem_read", {31'd0, memRead}, 32'd0);
    checkOutput("idle.counter_on", {31'd0, counterOn}, 32'd0);
    nextCycle();
    applyStimulus(32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("t1.req.mem_read", {31'd0, memRead}, 32'd1);
    checkOutput("t1.req.mem_addr", memAddr, 32'h0);
    checkOutput("t1.req.counter_on", {31'd0, counterOn}, 32'd0);
    nextCycle();
    applyStimulus(32'h0, 1'b0, 1'b1, 32'h00A0_0093, 1'b1);
    checkOutput("t1.wait.mem_read", {31'd0, memRead}, 32'd0);
    checkOutput("t1.wait.instr_valid", {31'd0, instrValid}, 32'd0);
    nextCycle();
    applyStimulus(32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("t1.hold.instr_valid", {31'd0, instrValid}, 32'd1);
    checkOutput("t1.hold.instr", instr, 32'h00A0_0093);
    checkOutput("t1.hold.misaligned", {31'd0, misaligned}, 32'd0);
    checkOutput("t1.hold.counter_on", {31'd0, counterOn}, 32'd1);
    nextCycle();

    // Busy for 4 cycles at pc 0x10; an ack during busy must be ignored.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(32'h10, 1'b1, (i == 2), 32'hBAD0_0000, 1'b0);
      checkOutput($sformatf("t2.busy%0d.mem_read", i), {31'd0, memRead}, 32'd1);
      checkOutput($sformatf("t2.busy%0d.mem_addr", i), memAddr, 32'h10);
      checkOutput($sformatf("t2.busy%0d.counter_on", i), {31'd0, counterOn}, 32'd0);
      nextCycle();
    end
    applyStimulus(32'h10, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("t2.accept.mem_read", {31'd0, memRead}, 32'd1);
    checkOutput("t2.accept.mem_addr", memAddr, 32'h10);
    nextCycle();
    // The latched address must be driven even if pc moves during WAIT.
    applyStimulus(32'h14, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("t2.wait.mem_read", {31'd0, memRead}, 32'd0);
    checkOutput("t2.wait.mem_addr", memAddr, 32'h10);
    checkOutput("t2.wait.instr_valid", {31'd0, instrValid}, 32'd0);
    nextCycle();
    applyStimulus(32'h10, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    nextCycle();

    // Decoder stalls 6 cycles; a stray ack in HOLD must not disturb instr.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(32'h10, 1'b0, (i == 3), 32'h5555_AAAA, 1'b0);
      checkOutput($sformatf("t3.stall%0d.instr", i), instr, 32'hDEAD_BEEF);
      checkOutput($sformatf("t3.stall%0d.valid", i), {31'd0, instrValid}, 32'd1);
      checkOutput($sformatf("t3.stall%0d.counter_on", i), {31'd0, counterOn}, 32'd0);
      checkOutput($sformatf("t3.stall%0d.mem_read", i), {31'd0, memRead}, 32'd0);
      nextCycle();
    end
    applyStimulus(32'h10, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("t3.ready.counter_on", {31'd0, counterOn}, 32'd1);
    nextCycle();

    // Misaligned pc 6: no read, NOP held with misaligned; ready in REQ ignored.
    applyStimulus(32'h6, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("t4.req.mem_read", {31'd0, memRead}, 32'd0);
    checkOutput("t4.req.counter_on", {31'd0, counterOn}, 32'd0);
    nextCycle();
    applyStimulus(32'h6, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("t4.hold.instr", instr, NOP);
    checkOutput("t4.hold.misaligned", {31'd0, misaligned}, 32'd1);
    checkOutput("t4.hold.valid", {31'd0, instrValid}, 32'd1);
    checkOutput("t4.hold.counter_on", {31'd0, counterOn}, 32'd1);
    checkOutput("t4.hold.mem_read", {31'd0, memRead}, 32'd0);
    nextCycle();

    // Fetch at 0x20 with an ack in REQ (ignored) and no ack afterwards.
    applyStimulus(32'h20, 1'b0, 1'b1, 32'h7777_7777, 1'b0);
    checkOutput("t5.req.mem_read", {31'd0, memRead}, 32'd1);
    nextCycle();
`ifdef T08_IFETCH_TIMEOUT_EN
    for (int i = 0; i < 7; i++) begin
      applyStimulus(32'h20, 1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput($sformatf("t5.wait%0d.valid", i), {31'd0, instrValid}, 32'd0);
      checkOutput($sformatf("t5.wait%0d.fault", i), {31'd0, fetchFault}, 32'd0);
      nextCycle();
    end
    applyStimulus(32'h20, 1'b0, 1'b1, 32'h9999_9999, 1'b0);
    checkOutput("t5.timeout.fault", {31'd0, fetchFault}, 32'd1);
    checkOutput("t5.timeout.instr", instr, NOP);
    checkOutput("t5.timeout.valid", {31'd0, instrValid}, 32'd1);
    nextCycle();
    applyStimulus(32'h20, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("t5.stray.instr", instr, NOP);
    checkOutput("t5.stray.fault", {31'd0, fetchFault}, 32'd1);
    checkOutput("t5.stray.counter_on", {31'd0, counterOn}, 32'd1);
    nextCycle();
`else
    for (int i = 0; i < 20; i++) begin
      applyStimulus(32'h20, 1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput($sformatf("t5.wait%0d.valid", i), {31'd0, instrValid}, 32'd0);
      checkOutput($sformatf("t5.wait%0d.mem_read", i), {31'd0, memRead}, 32'd0);
      checkOutput($sformatf("t5.wait%0d.fault", i), {31'd0, fetchFault}, 32'd0);
      nextCycle();
    end
    applyStimulus(32'h20, 1'b0, 1'b1, 32'h1234_5678, 1'b0);
    nextCycle();
    applyStimulus(32'h20, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("t5.late.instr", instr, 32'h1234_5678);
    checkOutput("t5.late.misaligned", {31'd0, misaligned}, 32'd0);
    checkOutput("t5.late.counter_on", {31'd0, counterOn}, 32'd1);
    nextCycle();
`endif

    // Reset asserted while in WAIT, then a normal fetch from IDLE.
    applyStimulus(32'h30, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("t6.req.mem_addr", memAddr, 32'h30);
    nextCycle();
    applyStimulus(32'h30, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("t6.wait.mem_addr", memAddr, 32'h30);
    nrst = 1'b0;
    #1;
    checkResetValues("t6.midreset");
    nextCycle();
    nrst = 1'b1;
    applyStimulus(32'h40, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("t6.idle.mem_read", {31'd0, memRead}, 32'd0);
    nextCycle();
    applyStimulus(32'h40, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("t6.req.mem_read", {31'd0, memRead}, 32'd1);
    checkOutput("t6.req2.mem_addr", memAddr, 32'h40);
    nextCycle();
    applyStimulus(32'h40, 1'b0, 1'b1, 32'h0000_0517, 1'b0);
    nextCycle();
    applyStimulus(32'h40, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("t6.hold.instr", instr, 32'h0000_0517);
    checkOutput("t6.hold.valid", {31'd0, instrValid}, 32'd1);
    checkOutput("t6.hold.counter_on", {31'd0, counterOn}, 32'd1);
    nextCycle();
    applyStimulus(32'h44, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("t6.after.counter_on", {31'd0, counterOn}, 32'd0);
    checkOutput("t6.after.valid", {31'd0, instrValid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/t08_imem_fetch_ctrl.md
# t08_imem_fetch_ctrl

Instruction-memory fetch controller that sits directly downstream of the program-counter stage. It takes the current `program_counter`, issues one read per instruction on the instruction-memory bus, and holds the returned word for the decoder. It produces the `counter_on` pulse that lets the PC stage advance (or jump/branch) only after the decoder has consumed the instruction.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: bus-wait limit in cycles; used only when the timeout feature is compiled in.
- `NOP_INSTR`, default 32'h0000_0013: word presented on reset, on a misaligned PC, and on a timeout.

Ports (reset nrst, asynchronous, active-low; clock clk):
- `clk`  in  1  clock, rising edge
- `nrst`  in  1  asynchronous active-low reset
- `pc`  in  32  program counter from the PC stage
- `mem_busy`  in  1  memory cannot accept a request this cycle
- `mem_ack`  in  1  read data valid this cycle
- `mem_rdata`  in  32  read data
- `mem_read`  out  1  read request
- `mem_addr`  out  32  request address
- `instr`  out  32  held instruction to the decoder
- `instr_valid`  out  1  `instr` is valid
- `instr_ready`  in  1  decoder consumes `instr` this cycle
- `counter_on`  out  1  one-cycle PC-advance strobe to the PC stage
- `misaligned`  out  1  the held instruction came from a PC with `pc[1:0]` != 0
- `fetch_fault`  out  1  sticky bus-timeout flag

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD. Reset enters IDLE.
- **IDLE:** all outputs inactive; moves to REQ on the next cycle.
- **REQ:** `mem_addr` = `pc`.
  - If `pc[1:0]` != 0: no request; `instr` <= `NOP_INSTR`, `misaligned` <= 1; next state HOLD.
  - Otherwise `mem_read` = 1. The request is accepted when `mem_read` & !`mem_busy`; then the address is latched and the FSM goes to WAIT. While `mem_busy` = 1 the FSM stays in REQ with `mem_read` held high.
- **WAIT:** `mem_read` = 0 and `mem_addr` = the latched address. On `mem_ack`: `instr` <= `mem_rdata`, `misaligned` <= 0, next state HOLD.
- `mem_ack` is ignored in every state except WAIT. Only one request is ever outstanding.
- **HOLD:** `instr_valid` = 1 and `instr` is stable. When `instr_ready` = 1: `counter_on` = 1 combinationally in that same cycle (the PC updates at that edge) and the FSM goes to REQ.
- `counter_on` is 0 in every other state and cycle. `pc` is therefore stable from REQ through HOLD.
- Simultaneous events:
  - `mem_busy` and `mem_ack` in REQ: `mem_busy` wins and `mem_ack` is ignored.
  - `instr_ready` outside HOLD: ignored.
- Reset mid-operation: the in-flight transaction is abandoned. The memory side must not issue an ack after reset without a new request.

## Timing
- Reset values: `mem_read` 0, `mem_addr` 0, `instr` `NOP_INSTR`, `instr_valid` 0, `counter_on` 0, `misaligned` 0, `fetch_fault` 0.
- Minimum cycles per instruction is 3 (REQ, WAIT with ack, HOLD with ready). Each cycle of busy, ack delay or ready delay adds one cycle.
- `instr` and `instr_valid` are registered. `mem_read`, `mem_addr` and `counter_on` are decoded from the state and registers.
- The earliest ack is the cycle after acceptance.

## Configuration
- `T08_IFETCH_TIMEOUT_EN` defined:
  - A counter clears on entry to REQ and increments each cycle spent in REQ or WAIT.
  - When it reaches `TIMEOUT_CYCLES`, `fetch_fault` <= 1 (sticky until reset), `instr` <= `NOP_INSTR`, and the FSM goes to HOLD.
  - A later stray ack is ignored unless it arrives in WAIT.
- Undefined: no counter, `fetch_fault` tied to 0, and the FSM waits indefinitely.

## Test plan
- Reset, then `pc`=0x0000_0000, `mem_busy`=0, ack 1 cycle after the request with `mem_rdata`=0x00A0_0093, `instr_ready`=1 → `mem_read` for exactly 1 cycle, `instr_valid` high 2 cycles after the request, `counter_on` pulses exactly once per instruction.
- `mem_busy` high for 4 cycles at `pc`=0x10 → `mem_read` and `mem_addr`=0x10 held for 5 cycles; exactly one transaction occurs.
- `instr_ready` held low for 6 cycles in HOLD → `instr` stable, `counter_on` stays 0 until ready, then 1 for a single cycle.
- `pc`=0x0000_0006 → no `mem_read`, `instr`=0x0000_0013, `misaligned`=1, `counter_on` on ready.
- With `T08_IFETCH_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, never ack → `fetch_fault`=1 after 8 cycles, `instr`=`NOP_INSTR`; a stray ack later in HOLD is ignored.
- Assert `nrst` while in WAIT → all outputs return to reset values immediately; normal fetch resumes from IDLE after release.
